// File: rtl/clk_divider_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_divider_prog_if
// Purpose  : Control/status bundle for the programmable clock divider.
//            The master side drives enable/restart/divisor loads and
//            observes the divided outputs; the slave side is the divider.
// Signals  : enable       - counter advance enable
//            restart      - synchronous counter restart
//            div_load     - one-cycle divisor load strobe
//            div_value    - divisor sampled with div_load
//            clk_div      - divided square wave
//            tick         - one-cycle pulse per divided period
//            div_cur      - active divisor
//            load_pending - a shadow divisor awaits application
//            cfg_err      - one-cycle pulse on a rejected load
// Revision : 1.0 - initial release
// ============================================================================
interface clk_divider_prog_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             restart;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             clk_div;
  logic             tick;
  logic [WIDTH-1:0] div_cur;
  logic             load_pending;
  logic             cfg_err;

  modport master (
    output enable, restart, div_load, div_value,
    input  clk_div, tick, div_cur, load_pending, cfg_err
  );

  modport slave (
    input  enable, restart, div_load, div_value,
    output clk_div, tick, div_cur, load_pending, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/clk_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_divider_prog
// Purpose  : Programmable clock divider producing a registered square wave
//            (low ceil(N/2), high floor(N/2) cycles) and a once-per-period
//            tick. New divisors are held in a shadow register and applied
//            only at a period boundary (wrap) or on restart, so the output
//            never produces a truncated period.
// Ports    : clk - clock, all state on the rising edge
//            rst - synchronous active-high reset
//            bus - clk_divider_prog_if.slave control/status bundle
// Revision : 1.0 - initial release
// ============================================================================
module clk_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DIV_DEFAULT = 2
) (
  input wire               clk,
  input wire               rst,
  clk_divider_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] C_DIV_DEFAULT = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] C_ZERO        = '0;
  localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TWO         = WIDTH'(2);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  logic             r_clk_div;
  logic             r_tick;
  logic             r_cfg_err;

  logic             w_at_wrap;
  logic             w_load_ok;
  logic             w_apply;
  logic [WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH:0]   w_half;
  logic             w_clk_next;

  always_comb begin
    w_at_wrap    = (r_count == (r_div - C_ONE));
    w_load_ok    = bus.div_load && (bus.div_value >= C_TWO);
    // Divisor changes only at a period boundary or on restart.
    w_apply      = bus.restart || (bus.enable && w_at_wrap);

    w_div_next   = r_div;
    if (w_apply) begin
      // A load arriving on the applying edge wins over an older shadow.
      if (w_load_ok) begin
        w_div_next = bus.div_value;
      end else if (r_pending) begin
        w_div_next = r_shadow;
      end
    end

    w_count_next = r_count;
    if (bus.restart) begin
      w_count_next = C_ZERO;
    end else if (bus.enable) begin
      w_count_next = w_at_wrap ? C_ZERO : (r_count + C_ONE);
    end

    // clk_div is registered from the next count/divisor so it always tracks
    // the count held in the same cycle. One extra bit avoids overflow of N+1.
    w_half     = ({1'b0, w_div_next} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    w_clk_next = ({1'b0, w_count_next} >= w_half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= C_ZERO;
      r_div     <= C_DIV_DEFAULT;
      r_shadow  <= C_DIV_DEFAULT;
      r_pending <= 1'b0;
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_div     <= w_div_next;
      r_clk_div <= w_clk_next;
      r_tick    <= !bus.restart && bus.enable && w_at_wrap;
      r_cfg_err <= bus.div_load && !w_load_ok;
      if (w_load_ok) begin
        r_shadow <= bus.div_value;
      end
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (w_load_ok) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.clk_div      = r_clk_div;
  assign bus.tick         = r_tick;
  assign bus.div_cur      = r_div;
  assign bus.load_pending = r_pending;
  assign bus.cfg_err      = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_divider_prog
// Purpose  : Self-checking bench for clk_divider_prog (WIDTH=16,
//            DIV_DEFAULT=2). Each cycle's inputs and expected post-edge
//            outputs form one record; expectations are queued when the
//            inputs are driven and compared after the following edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_divider_prog;

  localparam int WIDTH = 16;

  typedef struct {
    logic             rst;
    logic             en;
    logic             rs;
    logic             ld;
    logic [WIDTH-1:0] dv;
    logic             clk_div;
    logic             tick;
    logic [WIDTH-1:0] cur;
    logic             pend;
    logic             err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_q[$];

  clk_divider_prog_if #(.WIDTH(WIDTH)) bus ();

  clk_divider_prog #(.WIDTH(WIDTH), .DIV_DEFAULT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic e, input logic s,
                              input logic l, input int dv, input logic ck,
                              input logic tk, input int cur, input logic pd,
                              input logic er);
    vec_t v;
    v.rst = r; v.en = e; v.rs = s; v.ld = l; v.dv = WIDTH'(dv);
    v.clk_div = ck; v.tick = tk; v.cur = WIDTH'(cur); v.pend = pd; v.err = er;
    return v;
  endfunction

  task automatic check(input string name, input string fld,
                       input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", name, fld, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic cyc(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    rst           = v.rst;
    bus.enable    = v.en;
    bus.restart   = v.rs;
    bus.div_load  = v.ld;
    bus.div_value = v.dv;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, "clk_div",      32'(bus.clk_div),      32'(e.clk_div));
    check(name, "tick",         32'(bus.tick),         32'(e.tick));
    check(name, "div_cur",      32'(bus.div_cur),      32'(e.cur));
    check(name, "load_pending", 32'(bus.load_pending), 32'(e.pend));
    check(name, "cfg_err",      32'(bus.cfg_err),      32'(e.err));
  endtask

  // Free-running enabled cycles with divisor n and no load activity.
  task automatic run_en(input int n, inout int cnt, input int ncyc,
                        input logic pend, input string name);
    for (int k = 0; k < ncyc; k++) begin
      int   nxt;
      logic tk;
      logic ck;
      tk  = (cnt == n - 1);
      nxt = tk ? 0 : cnt + 1;
      ck  = (nxt >= (n + 1) / 2);
      cyc(mk(0, 1, 0, 0, 0, ck, tk, n, pend, 0), name);
      cnt = nxt;
    end
  endtask

  vec_t tbl[21];
  int   cnt;

  initial begin
    bus.enable    = 1'b0;
    bus.restart   = 1'b0;
    bus.div_load  = 1'b0;
    bus.div_value = '0;

    //             rst en rs ld dv  clk tk cur pd er
    tbl[0]  = mk(1, 0, 0, 1, 7,  0, 0, 2, 0, 0);  // reset ignores load
    tbl[1]  = mk(1, 1, 0, 0, 0,  0, 0, 2, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0,  1, 0, 2, 0, 0);  // N=2 toggling
    tbl[3]  = mk(0, 1, 0, 0, 0,  0, 1, 2, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0,  1, 0, 2, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0,  0, 1, 2, 0, 0);
    tbl[6]  = mk(0, 1, 0, 1, 5,  1, 0, 2, 1, 0);  // load 5, pending
    tbl[7]  = mk(0, 1, 0, 0, 0,  0, 1, 5, 0, 0);  // wrap applies 5
    tbl[8]  = mk(0, 1, 0, 0, 0,  0, 0, 5, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0,  0, 0, 5, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0,  1, 0, 5, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0,  1, 0, 5, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 0,  0, 1, 5, 0, 0);
    tbl[13] = mk(0, 1, 0, 1, 1,  0, 0, 5, 0, 1);  // reject 1
    tbl[14] = mk(0, 1, 0, 0, 0,  0, 0, 5, 0, 0);
    tbl[15] = mk(0, 1, 0, 1, 0,  1, 0, 5, 0, 1);  // reject 0
    tbl[16] = mk(0, 1, 0, 0, 0,  1, 0, 5, 0, 0);
    tbl[17] = mk(0, 1, 0, 1, 3,  0, 1, 3, 0, 0);  // load on wrap edge
    tbl[18] = mk(0, 1, 0, 1, 7,  0, 0, 3, 1, 0);
    tbl[19] = mk(0, 1, 0, 1, 1,  1, 0, 3, 1, 1);  // reject keeps shadow
    tbl[20] = mk(0, 1, 0, 0, 0,  0, 1, 7, 0, 0);  // shadow 7 applied

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i], $sformatf("vec%0d", i));
    end
    cnt = 0;  // N=7, count=0

    // Load 8 then 3 mid-period; pending holds until the wrap.
    cyc(mk(0, 1, 0, 1, 8, 0, 0, 7, 1, 0), "ld8");
    cnt = 1;
    run_en(7, cnt, 5, 1'b1, "n7_pend");
    cyc(mk(0, 1, 0, 0, 0, 0, 1, 8, 0, 0), "wrap8");
    cnt = 0;
    run_en(8, cnt, 2, 1'b0, "n8");
    cyc(mk(0, 1, 0, 1, 3, 0, 0, 8, 1, 0), "ld3_at2");
    cnt = 3;
    run_en(8, cnt, 4, 1'b1, "n8_pend");
    cyc(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0), "wrap3");
    cnt = 0;
    run_en(3, cnt, 6, 1'b0, "n3");

    // N=6, freeze at count 4 for 10 cycles (load arrives while frozen).
    cyc(mk(0, 1, 0, 1, 6, 0, 0, 3, 1, 0), "ld6");
    cyc(mk(0, 1, 0, 0, 0, 1, 0, 3, 1, 0), "n3_c2");
    cyc(mk(0, 1, 0, 0, 0, 0, 1, 6, 0, 0), "wrap6");
    cnt = 0;
    run_en(6, cnt, 4, 1'b0, "n6");
    cyc(mk(0, 0, 0, 1, 4, 1, 0, 6, 1, 0), "frz_ld4");
    for (int k = 0; k < 9; k++) begin
      cyc(mk(0, 0, 0, 0, 0, 1, 0, 6, 1, 0), "frozen");
    end
    cyc(mk(0, 1, 0, 0, 0, 1, 0, 6, 1, 0), "resume_c5");
    cyc(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0), "wrap4");
    cnt = 0;
    run_en(4, cnt, 3, 1'b0, "n4");
    cyc(mk(0, 0, 0, 0, 0, 1, 0, 4, 0, 0), "frz_at_wrap");
    cyc(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0), "wrap_after_frz");
    cnt = 0;

    // Restart with a pending divisor at count 3, then reset mid-period.
    cyc(mk(0, 1, 0, 1, 9, 0, 0, 4, 1, 0), "ld9");
    cyc(mk(0, 1, 0, 0, 0, 1, 0, 4, 1, 0), "n4_c2");
    cyc(mk(0, 1, 0, 0, 0, 1, 0, 4, 1, 0), "n4_c3");
    cyc(mk(0, 1, 1, 0, 0, 0, 0, 9, 0, 0), "restart9");
    cyc(mk(0, 0, 1, 1, 5, 0, 0, 5, 0, 0), "restart_ld5");
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 5, 0, 0), "restart_idle");
    cnt = 0;
    run_en(5, cnt, 3, 1'b0, "n5");
    cyc(mk(0, 1, 0, 1, 12, 1, 0, 5, 1, 0), "ld12");
    cyc(mk(1, 1, 0, 1, 1,  0, 0, 2, 0, 0), "rst_mid");
    cyc(mk(0, 0, 0, 0, 0,  0, 0, 2, 0, 0), "post_rst");
    cnt = 0;
    run_en(2, cnt, 4, 1'b0, "n2_again");

    @(negedge clk);
    bus.enable = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the divisor and counter width; the legal range is 2..32.
REQ-002 The block SHALL have parameter DIV_DEFAULT, default 2, giving the divisor loaded at reset; it must satisfy 2 <= DIV_DEFAULT <= 2^WIDTH-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: when 1, the counter advances; when 0, it freezes.
REQ-006 Port restart, input, 1 bit: synchronous counter restart.
REQ-007 Port div_load, input, 1 bit: one-cycle strobe that requests a new divisor.
REQ-008 Port div_value, input, WIDTH bits: the divisor sampled when div_load=1.
REQ-009 Port clk_div, output, 1 bit: registered divided square wave.
REQ-010 Port tick, output, 1 bit: registered one-cycle pulse, once per divided period.
REQ-011 Port div_cur, output, WIDTH bits: the active divisor N.
REQ-012 Port load_pending, output, 1 bit: a shadow divisor is waiting to be applied.
REQ-013 Port cfg_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-014 The block SHALL be fully synchronous in the clk domain: no derived clocks, no ripple stages.
REQ-015 Internal count (WIDTH bits) SHALL, on an edge with enable=1, load 0 if count==N-1, else load count+1.
REQ-016 With enable=1, tick SHALL be registered as (count==N-1), so tick=1 during exactly the cycle in which count==0 following a wrap.
REQ-017 In every cycle, clk_div SHALL equal 1 exactly when count >= ceil(N/2), giving low for ceil(N/2) cycles and high for floor(N/2) cycles per period; for N=5 that is counts 0-2 low and counts 3-4 high.
REQ-018 With enable=0, count and clk_div SHALL hold their values and tick SHALL be 0 on the next cycle.
REQ-019 When div_load=1 and div_value>=2, div_value SHALL be stored in a shadow register and load_pending SHALL be set on the next cycle.
REQ-020 When div_load=1 and div_value<2, the request SHALL be ignored, cfg_err SHALL be 1 for exactly the next cycle, and the shadow register and load_pending SHALL be unchanged.
REQ-021 A second valid div_load while load_pending=1 SHALL overwrite the shadow register (last request wins).
REQ-022 A pending divisor SHALL be applied only at a wrap edge (enable=1 and count==N-1) or on restart; on that edge N takes the shadow value and load_pending clears.
REQ-023 When a valid div_load coincides with a wrap edge, the value being loaded SHALL be applied at that same edge and load_pending SHALL remain 0.
REQ-024 While enable=0, load_pending SHALL stay set until the first wrap edge after enable returns to 1, or until a restart.
REQ-025 When restart=1, count, clk_div and tick SHALL be set to 0 and any pending divisor (including one loaded in the same cycle) SHALL be applied, regardless of enable.
REQ-026 Priority SHALL be rst > restart > enable-driven counting.
REQ-027 div_cur SHALL always equal N, changing only on a reset, wrap or restart edge.

Reset
REQ-028 On an edge with rst=1, the block SHALL set count=0, clk_div=0, tick=0, cfg_err=0, load_pending=0, and N=div_cur=DIV_DEFAULT, ignoring all other inputs in that cycle.
REQ-029 Reset asserted mid-period SHALL discard the pending divisor and the partial count; counting restarts at count=0 on the first enabled edge after rst deasserts.

Verification
REQ-030 Bench: reset, enable=1, default N=2 -> clk_div sequence 0,1,0,1…; tick=1 every 2nd cycle starting at cycle 2 after reset release.
REQ-031 Bench: load N=5, then one wrap -> clk_div low 3 cycles / high 2 cycles; tick once per 5 cycles; div_cur=5 only after the wrap.
REQ-032 Bench: N=8, load 3 when count=2 -> load_pending=1 through count 7; at wrap div_cur=3, load_pending=0; then period is 3.
REQ-033 Bench: div_value=1 and div_value=0 loads -> cfg_err pulses 1 cycle each; div_cur and load_pending unchanged.
REQ-034 Bench: N=6, enable=0 at count=4 for 10 cycles -> count and clk_div frozen, tick=0; resuming gives count 5, then wrap.
REQ-035 Bench: restart with pending load at count=3, then rst mid-period -> restart applies the new divisor immediately; rst returns div_cur=DIV_DEFAULT with all outputs 0.
